// File: rtl/clk_tick_sched_pkg.sv
// -----------------------------------------------------------------------------
// clk_tick_sched_pkg
// Shared definitions for the board-clock tick scheduler:
//   - scheduler state encodings (IDLE / RUN / PEND)
//   - baud-select codes and their baud rates
//   - dds_inc(): rounded phase increment round(f_out * 2^acc_w / f_clk),
//     used to build the UART increment table and the VGA constant.
// -----------------------------------------------------------------------------
package clk_tick_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } sched_state_e;

  localparam logic [1:0] BAUD_9600   = 2'd0;
  localparam logic [1:0] BAUD_19200  = 2'd1;
  localparam logic [1:0] BAUD_57600  = 2'd2;
  localparam logic [1:0] BAUD_115200 = 2'd3;

  // UART receivers sample at 16x the bit rate.
  localparam longint unsigned UART_OVERSAMPLE = 64'd16;

  function automatic longint unsigned baud_hz(input logic [1:0] sel);
    case (sel)
      BAUD_9600:   return 64'd9600;
      BAUD_19200:  return 64'd19200;
      BAUD_57600:  return 64'd57600;
      default:     return 64'd115200;
    endcase
  endfunction

  // Round-to-nearest phase increment. f_out * 2^acc_w must fit in 64 bits.
  function automatic longint unsigned dds_inc(input longint unsigned f_out,
                                              input longint unsigned f_clk,
                                              input int unsigned     acc_w);
    return ((f_out << acc_w) + (f_clk >> 1)) / f_clk;
  endfunction

endpackage

// File: rtl/clk_tick_sched_accum.sv
// -----------------------------------------------------------------------------
// tick_accum
// One DDS phase accumulator with a registered overflow tick.
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   inc      in   ACC_W phase increment
//   run      in   add inc every cycle while high
//   clear    in   force accumulator and tick to 0 (wins over run)
//   restart  in   zero the accumulator after this add, but still register
//                 the carry of this add as a tick
//   tick     out  high for the one cycle after an overflowing add
//   carry    out  combinational carry of the add about to be registered
// -----------------------------------------------------------------------------
module tick_accum #(
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] inc,
  input  logic             run,
  input  logic             clear,
  input  logic             restart,
  output logic             tick,
  output logic             carry
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, inc};
  assign carry = run & sum[ACC_W];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (run) begin
      tick <= sum[ACC_W];
      acc  <= restart ? '0 : sum[ACC_W-1:0];
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_tick_sched.sv
// -----------------------------------------------------------------------------
// clk_tick_sched
// Clock-enable scheduler for the board clock domain. Two DDS accumulators on
// clk_board produce single-cycle enables: uart_tick at 16x the selected baud
// and vga_tick at VGA_FREQ. A small FSM sequences run/stop and retunes the
// UART rate only on a UART tick boundary.
//
// Build option: define CLK_TICK_SCHED_VGA_EN to build the VGA accumulator;
// otherwise vga_tick is tied to 0 and the UART path is unchanged.
//
// Ports:
//   clk_board     in   board clock (only clock)
//   reset         in   synchronous, active-high
//   enable        in   1 = run tick generation, 0 = stop and clear
//   cfg_valid     in   baud change request
//   cfg_baud_sel  in   [1:0] requested baud select
//   cfg_ready     out  request accepted when cfg_valid & cfg_ready
//   baud_sel_q    out  [1:0] baud select in effect
//   busy          out  a baud change is pending
//   uart_tick     out  1-cycle enable at 16x baud
//   vga_tick      out  1-cycle enable at VGA_FREQ
// -----------------------------------------------------------------------------
module clk_tick_sched
  import clk_tick_sched_pkg::*;
#(
  parameter int unsigned BOARD_FREQ       = 50000000,
  parameter int unsigned VGA_FREQ         = 25175000,
  parameter int unsigned ACC_W            = 32,
  parameter logic [1:0]  BAUD_SEL_DEFAULT = 2'd0
) (
  input  logic       clk_board,
  input  logic       reset,
  input  logic       enable,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_baud_sel,
  output logic       cfg_ready,
  output logic [1:0] baud_sel_q,
  output logic       busy,
  output logic       uart_tick,
  output logic       vga_tick
);

  localparam longint unsigned BOARD_HZ = 64'(BOARD_FREQ);

  localparam logic [ACC_W-1:0] UART_INC_0 =
    ACC_W'(dds_inc(UART_OVERSAMPLE * baud_hz(BAUD_9600),   BOARD_HZ, ACC_W));
  localparam logic [ACC_W-1:0] UART_INC_1 =
    ACC_W'(dds_inc(UART_OVERSAMPLE * baud_hz(BAUD_19200),  BOARD_HZ, ACC_W));
  localparam logic [ACC_W-1:0] UART_INC_2 =
    ACC_W'(dds_inc(UART_OVERSAMPLE * baud_hz(BAUD_57600),  BOARD_HZ, ACC_W));
  localparam logic [ACC_W-1:0] UART_INC_3 =
    ACC_W'(dds_inc(UART_OVERSAMPLE * baud_hz(BAUD_115200), BOARD_HZ, ACC_W));
  localparam logic [ACC_W-1:0] VGA_INC =
    ACC_W'(dds_inc(64'(VGA_FREQ), BOARD_HZ, ACC_W));

  sched_state_e     state_q, state_d;
  logic [1:0]       baud_d;
  logic [1:0]       pend_sel_q, pend_sel_d;
  logic [ACC_W-1:0] uart_inc;
  logic             acc_run;
  logic             acc_clear;
  logic             uart_restart;
  logic             uart_carry;

  always_comb begin
    case (baud_sel_q)
      BAUD_9600:  uart_inc = UART_INC_0;
      BAUD_19200: uart_inc = UART_INC_1;
      BAUD_57600: uart_inc = UART_INC_2;
      default:    uart_inc = UART_INC_3;
    endcase
  end

  always_ff @(posedge clk_board) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_sel_q <= BAUD_SEL_DEFAULT;
      pend_sel_q <= BAUD_SEL_DEFAULT;
    end else begin
      state_q    <= state_d;
      baud_sel_q <= baud_d;
      pend_sel_q <= pend_sel_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_sel_q;
    pend_sel_d   = pend_sel_q;
    acc_clear    = 1'b0;
    uart_restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Accumulators stay at 0; the first add happens the edge after RUN
        // is entered.
        acc_clear = 1'b1;
        if (cfg_valid) baud_d = cfg_baud_sel;
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          // Stop wins over a simultaneous request, which is applied directly.
          acc_clear = 1'b1;
          state_d   = ST_IDLE;
          if (cfg_valid) baud_d = cfg_baud_sel;
        end else if (cfg_valid) begin
          pend_sel_d = cfg_baud_sel;
          state_d    = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!enable) begin
          acc_clear = 1'b1;
          state_d   = ST_IDLE;
          baud_d    = pend_sel_q;
        end else if (uart_carry) begin
          // The tick for this carry is still issued; the new rate starts
          // from a zero phase on the following add.
          uart_restart = 1'b1;
          baud_d       = pend_sel_q;
          state_d      = ST_RUN;
        end
      end
      default: begin
        acc_clear = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase
  end

  assign acc_run   = (state_q != ST_IDLE);
  assign cfg_ready = (state_q != ST_PEND);
  assign busy      = (state_q == ST_PEND);

  tick_accum #(.ACC_W(ACC_W)) u_uart_accum (
    .clk     (clk_board),
    .rst     (reset),
    .inc     (uart_inc),
    .run     (acc_run),
    .clear   (acc_clear),
    .restart (uart_restart),
    .tick    (uart_tick),
    .carry   (uart_carry)
  );

`ifdef CLK_TICK_SCHED_VGA_EN
  logic vga_carry_unused;

  tick_accum #(.ACC_W(ACC_W)) u_vga_accum (
    .clk     (clk_board),
    .rst     (reset),
    .inc     (VGA_INC),
    .run     (acc_run),
    .clear   (acc_clear),
    .restart (1'b0),
    .tick    (vga_tick),
    .carry   (vga_carry_unused)
  );
`else
  logic vga_inc_unused;

  assign vga_inc_unused = ^VGA_INC;
  assign vga_tick       = 1'b0;
`endif

endmodule

// File: tb/tb_clk_tick_sched.sv
module tb_clk_tick_sched;

`ifdef CLK_TICK_SCHED_VGA_EN
  localparam bit VGA_ON = 1'b1;
`else
  localparam bit VGA_ON = 1'b0;
`endif

  localparam longint unsigned VINC = 64'd2162516034;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_baud_sel = 2'd0;
  logic       cfg_ready;
  logic [1:0] baud_sel_q;
  logic       busy;
  logic       uart_tick;
  logic       vga_tick;

  always #5 clk = ~clk;

  clk_tick_sched dut (
    .clk_board    (clk),
    .reset        (reset),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_baud_sel (cfg_baud_sel),
    .cfg_ready    (cfg_ready),
    .baud_sel_q   (baud_sel_q),
    .busy         (busy),
    .uart_tick    (uart_tick),
    .vga_tick     (vga_tick)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ticks come from counting adds since the last phase
  // restart; add k issues a tick when floor(k*inc/2^32) steps up.
  bit              m_run, m_pend, m_tu, m_tv;
  bit [1:0]        m_sel, m_psel;
  longint unsigned m_ku, m_kv;

  function automatic longint unsigned uinc(input bit [1:0] sel);
    case (sel)
      2'd0:    return 64'd13194140;
      2'd1:    return 64'd26388279;
      2'd2:    return 64'd79164837;
      default: return 64'd158329674;
    endcase
  endfunction

  function automatic bit crosses(input longint unsigned k, input longint unsigned inc);
    return ((k * inc) >> 32) != (((k - 1) * inc) >> 32);
  endfunction

  task automatic model_step(input bit r, input bit e, input bit v, input bit [1:0] s);
    m_tu = 1'b0;
    m_tv = 1'b0;
    if (r) begin
      m_run = 0; m_pend = 0; m_sel = 2'd0; m_psel = 2'd0; m_ku = 0; m_kv = 0;
    end else if (!m_run) begin
      if (v) m_sel = s;
      if (e) m_run = 1;
      m_ku = 0; m_kv = 0;
    end else if (!e) begin
      if (m_pend) m_sel = m_psel;
      else if (v) m_sel = s;
      m_run = 0; m_pend = 0; m_ku = 0; m_kv = 0;
    end else begin
      m_ku++;
      m_kv++;
      m_tu = crosses(m_ku, uinc(m_sel));
      m_tv = VGA_ON && crosses(m_kv, VINC);
      if (m_pend && m_tu) begin
        m_sel = m_psel; m_pend = 0; m_ku = 0;
      end else if (!m_pend && v) begin
        m_pend = 1; m_psel = s;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input bit r, input bit e, input bit v, input bit [1:0] s);
    reset = r; enable = e; cfg_valid = v; cfg_baud_sel = s;
    @(posedge clk);
    model_step(r, e, v, s);
    #1;
    check("model {ready,busy,sel,utick,vtick}",
          {58'd0, cfg_ready, busy, baud_sel_q, uart_tick, vga_tick},
          {58'd0, !m_pend, m_pend, m_sel, m_tu, m_tv});
  endtask

  // Run with enable=1 until a uart_tick appears or the limit expires.
  // busy_ok drops if any non-tick cycle is not in the pending state.
  task automatic wait_uart(input bit v, input bit [1:0] s, input int limit,
                           output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    do begin
      apply(0, 1, v, s);
      n++;
      if (!uart_tick && !(busy === 1'b1 && cfg_ready === 1'b0)) busy_ok = 1'b0;
    end while (uart_tick !== 1'b1 && n < limit);
    check("uart_tick within limit", uart_tick, 1);
  endtask

  typedef struct {
    bit       rst, en, cv;
    bit [1:0] cs;
    bit       ready, busy;
    bit [1:0] sel;
    bit       tu, tv;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n, first, cu, cvc;
    bit ok;

    vecs[0] = '{1, 0, 0, 2'd0, 1, 0, 2'd0, 0, 0};       // reset state
    vecs[1] = '{0, 0, 1, 2'd2, 1, 0, 2'd2, 0, 0};       // IDLE transfer
    vecs[2] = '{0, 1, 0, 2'd0, 1, 0, 2'd2, 0, 0};       // IDLE -> RUN
    vecs[3] = '{0, 1, 1, 2'd3, 0, 1, 2'd2, 0, 0};       // RUN transfer -> PEND
    vecs[4] = '{0, 1, 1, 2'd0, 0, 1, 2'd2, 0, VGA_ON};  // held in PEND
    vecs[5] = '{0, 0, 0, 2'd0, 1, 0, 2'd3, 0, 0};       // stop applies pend_sel
    vecs[6] = '{0, 1, 1, 2'd1, 1, 0, 2'd1, 0, 0};       // IDLE transfer + enable
    vecs[7] = '{0, 0, 1, 2'd2, 1, 0, 2'd2, 0, 0};       // stop + cfg in RUN
    vecs[8] = '{1, 0, 0, 2'd0, 1, 0, 2'd0, 0, 0};       // reset again

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].rst, vecs[i].en, vecs[i].cv, vecs[i].cs);
      check($sformatf("vec%0d {ready,busy,sel,utick,vtick}", i),
            {58'd0, cfg_ready, busy, baud_sel_q, uart_tick, vga_tick},
            {58'd0, vecs[i].ready, vecs[i].busy, vecs[i].sel, vecs[i].tu, vecs[i].tv});
    end

    // Free run at 9600: first tick latency and tick counts over 20000 cycles.
    apply(1, 0, 0, 0);
    apply(0, 1, 0, 0);
    n = 0; first = -1; cu = 0; cvc = 0;
    while (n < 20000) begin
      apply(0, 1, 0, 0);
      n++;
      if (uart_tick === 1'b1) begin
        if (cu == 0) first = n;
        cu++;
      end
      if (vga_tick === 1'b1) cvc++;
    end
    check("t1 first uart_tick cycles", first, 326);
    check("t1 uart_tick count", cu, 61);
    check("t1 vga_tick count", cvc, VGA_ON ? 10070 : 0);

    // Retune to 115200: change lands on the next carry, then 28-cycle period.
    check("t2 cfg_ready in RUN", cfg_ready, 1);
    apply(0, 1, 1, 2'd3);
    check("t2 busy after transfer", busy, 1);
    wait_uart(0, 2'd0, 400, n, ok);
    check("t2 busy held until carry", ok, 1);
    check("t2 busy after carry", busy, 0);
    check("t2 baud_sel_q", baud_sel_q, 3);
    wait_uart(0, 2'd0, 400, n, ok);
    check("t2 cycles to next tick", n, 28);

    // Request held through PEND is not taken; a new one is taken at once.
    apply(0, 1, 1, 2'd0);
    wait_uart(1, 2'd1, 400, n, ok);
    check("t3 ready low through PEND", ok, 1);
    check("t3 baud_sel_q after PEND", baud_sel_q, 0);
    check("t3 cfg_ready back in RUN", cfg_ready, 1);
    apply(0, 1, 1, 2'd2);
    check("t3 second request accepted", busy, 1);
    wait_uart(0, 2'd0, 400, n, ok);
    check("t3 baud_sel_q after second", baud_sel_q, 2);

    // Stop while pending: pend_sel applied, phases cleared.
    apply(0, 1, 1, 2'd1);
    check("t4 busy", busy, 1);
    apply(0, 0, 0, 2'd0);
    check("t4 busy after stop", busy, 0);
    check("t4 baud_sel_q after stop", baud_sel_q, 1);
    check("t4 ticks after stop", {uart_tick, vga_tick}, 0);
    apply(0, 0, 0, 2'd0);
    check("t4 ticks in IDLE", {uart_tick, vga_tick}, 0);
    apply(0, 1, 0, 2'd0);
    wait_uart(0, 2'd0, 400, n, ok);
    check("t4 first tick after re-enable", n, 163);

    // Reset on the very edge where the pending change would complete.
    apply(0, 1, 1, 2'd3);
    n = 0;
    while (!crosses(m_ku + 1, uinc(m_sel)) && n < 400) begin
      apply(0, 1, 0, 2'd0);
      n++;
    end
    check("t5 still pending before reset", busy, 1);
    apply(1, 1, 0, 2'd0);
    check("t5 baud_sel_q after reset", baud_sel_q, 0);
    check("t5 busy after reset", busy, 0);
    check("t5 cfg_ready after reset", cfg_ready, 1);
    check("t5 ticks after reset", {uart_tick, vga_tick}, 0);
    apply(0, 0, 0, 2'd0);
    check("t5 idle ticks", {uart_tick, vga_tick}, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 15000; i++) begin
      apply(($urandom % 2000) == 0, ($urandom % 300) != 0,
            ($urandom % 40) == 0, 2'($urandom % 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
